eth_tx_scheduler: RTL and testbench
===================================

ETH_TX_SCHEDULER -- requirements
Module: eth_tx_scheduler

Interface
REQ-001 Parameter FRAME_PIXELS, default 76800, pixels per video frame in BRAM.
REQ-002 Parameter PKT_PIXELS, default 1280, maximum pixels (payload bytes) per Ethernet packet.
REQ-003 Parameter IFG_CYCLES, default 48, idle cycles between packets (96 bit-times at 2 bits/cycle).
REQ-004 Parameter TIMEOUT_CYCLES, default 8192, maximum SEND cycles before pkt_done.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 frame_valid  input  1  a complete frame is ready in BRAM.
REQ-008 frame_ready  output  1  scheduler accepts a frame.
REQ-009 abort  input  1  cancel the current frame.
REQ-010 pkt_done  input  1  one-cycle pulse from the packer: the packet has finished transmitting.
REQ-011 pkt_start  output  1  one-cycle pulse: start the packet described by pkt_base_addr and pkt_len.
REQ-012 pkt_base_addr  output  24  first BRAM pixel address of the packet.
REQ-013 pkt_len  output  11  pixels in the packet.
REQ-014 pkt_idx  output  8  packet number within the frame, starting at 0.
REQ-015 busy  output  1  a frame is in progress.
REQ-016 frame_done  output  1  one-cycle pulse: the last packet of the frame has completed.
REQ-017 timeout_err  output  1  sticky flag: a packet watchdog expired.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, START, SEND, GAP, DONE.
REQ-019 IDLE: frame_ready=1; on frame_valid&&frame_ready SHALL set base=0, idx=0, clear timeout_err, then go to START.
REQ-020 START: pkt_start=1 for exactly that cycle, then go to SEND; pkt_start SHALL be a Moore output of START.
REQ-021 pkt_len SHALL be PKT_PIXELS, except the last packet, which SHALL carry FRAME_PIXELS mod PKT_PIXELS when that value is nonzero.
REQ-022 Packet count SHALL be ceil(FRAME_PIXELS/PKT_PIXELS).
REQ-023 pkt_base_addr, pkt_len and pkt_idx SHALL be stable from START through the end of SEND.
REQ-024 pkt_done SHALL be sampled only in SEND; in all other states it SHALL be ignored.
REQ-025 SEND with pkt_done on the last packet SHALL go to DONE.
REQ-026 SEND with pkt_done on any other packet SHALL go to GAP and advance base by PKT_PIXELS and idx by 1.
REQ-027 GAP SHALL last exactly IFG_CYCLES cycles, then go to START.
REQ-028 Timing: pkt_done sampled at cycle t gives pkt_start at cycle t+IFG_CYCLES+1.
REQ-029 DONE: frame_done=1 for one cycle, then go to IDLE.
REQ-030 The watchdog SHALL count SEND cycles; on reaching TIMEOUT_CYCLES it SHALL set timeout_err and go to IDLE with no frame_done.
REQ-031 abort SHALL force IDLE on the next edge from any state.
REQ-032 abort SHALL take priority over pkt_done and the watchdog, and SHALL not produce frame_done.
REQ-033 busy SHALL equal (state != IDLE).
REQ-034 frame_valid while busy SHALL be ignored; no queueing.
REQ-035 Address arithmetic SHALL be 24-bit unsigned; a base address reaching FRAME_PIXELS is unreachable by construction.

Reset
REQ-036 While rst_n=0 the outputs SHALL be: state IDLE, frame_ready=1, pkt_start=0, frame_done=0, busy=0, timeout_err=0, pkt_base_addr=0, pkt_len=0, pkt_idx=0, counters=0.
REQ-037 Reset asserted mid-packet SHALL abandon the frame immediately, with no pulses generated on release.

Structure
REQ-038 Shared package eth_tx_pkg SHALL hold the state enum and the default constants (FRAME_PIXELS, PKT_PIXELS, IFG_CYCLES, TIMEOUT_CYCLES, address width 24).
REQ-039 One sub-module, cycle_timer, SHALL be a loadable down-counter with expiry flag, shared by the GAP and watchdog functions.

Verification (FRAME_PIXELS=10, PKT_PIXELS=4, IFG_CYCLES=3, TIMEOUT_CYCLES=20)
REQ-040 Single frame, pkt_done 5 cycles after each pkt_start -> three pkt_start pulses; (base,len,idx) = (0,4,0),(4,4,1),(8,2,2); each pulse 4 cycles after the prior pkt_done; frame_done 1 cycle after the 3rd pkt_done; frame_ready 2 cycles after it.
REQ-041 FRAME_PIXELS=8 -> exactly two packets, len 4 and 4, then frame_done.
REQ-042 Spurious pkt_done in GAP and START, plus frame_valid held high while busy -> no state change, no extra packet, no second frame.
REQ-043 abort during GAP after packet 0 -> IDLE next cycle; no pkt_start, no frame_done; next frame restarts at base 0.
REQ-044 No pkt_done after packet 1's pkt_start -> timeout_err=1 after 20 SEND cycles; IDLE; flag clears on next frame accept.
REQ-045 rst_n low mid-SEND -> all outputs at reset values asynchronously; no pulses after release.

Source files
------------

// File: rtl/eth_tx_pkg.sv
// Shared state encoding, packet descriptor type and default sizing for the TX scheduler.
package eth_tx_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 11;
    localparam int IDX_W  = 8;

    localparam int DEF_FRAME_PIXELS   = 76800;
    localparam int DEF_PKT_PIXELS     = 1280;
    localparam int DEF_IFG_CYCLES     = 48;
    localparam int DEF_TIMEOUT_CYCLES = 8192;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        GAP,
        DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [LEN_W-1:0]  len;
        logic [IDX_W-1:0]  idx;
    } pkt_desc_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable saturating down-counter; o_expired is high while the count sits at zero.
// Latency: load visible next cycle; no backpressure (decrement is a plain enable).
module cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expired
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/eth_tx_scheduler.sv
// Splits a BRAM-resident video frame into Ethernet packets, spacing them by an inter-frame gap.
// Latency: pkt_done -> next pkt_start is IFG_CYCLES+1 cycles; the packer throttles via pkt_done, frames via frame_ready.
module eth_tx_scheduler
    import eth_tx_pkg::*;
#(
    parameter int FRAME_PIXELS   = DEF_FRAME_PIXELS,
    parameter int PKT_PIXELS     = DEF_PKT_PIXELS,
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    output logic              frame_ready,
    input  logic              abort,
    input  logic              pkt_done,
    output logic              pkt_start,
    output logic [ADDR_W-1:0] pkt_base_addr,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [IDX_W-1:0]  pkt_idx,
    output logic              busy,
    output logic              frame_done,
    output logic              timeout_err
);

    localparam int NUM_PKTS = ceil_div(FRAME_PIXELS, PKT_PIXELS);
    localparam int LAST_IDX = NUM_PKTS - 1;
    localparam int REM_PIX  = FRAME_PIXELS % PKT_PIXELS;
    localparam int LAST_LEN = (REM_PIX != 0) ? REM_PIX : PKT_PIXELS;
    localparam int TMR_MAX  = (IFG_CYCLES > TIMEOUT_CYCLES) ? IFG_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    localparam logic [LEN_W-1:0]  FULL_LEN_V  = LEN_W'(PKT_PIXELS);
    localparam logic [LEN_W-1:0]  LAST_LEN_V  = LEN_W'(LAST_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX_V  = IDX_W'(LAST_IDX);
    localparam logic [ADDR_W-1:0] PKT_STEP_V  = ADDR_W'(PKT_PIXELS);
    localparam logic [LEN_W-1:0]  FIRST_LEN_V = (LAST_IDX == 0) ? LAST_LEN_V : FULL_LEN_V;
    localparam logic [TMR_W-1:0]  GAP_LOAD_V  = (IFG_CYCLES > 0) ? TMR_W'(IFG_CYCLES - 1) : '0;
    localparam logic [TMR_W-1:0]  WDOG_LOAD_V = (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t     r_state;
    state_t     w_nxt_state;
    pkt_desc_t  r_desc;
    logic       r_timeout_err;

    logic             w_accept;
    logic             w_advance;
    logic             w_set_timeout;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_dec;
    logic             w_tmr_exp;
    logic             w_last_pkt;
    logic             w_next_is_last;
    logic [IDX_W-1:0] w_idx_inc;

    assign w_idx_inc      = r_desc.idx + IDX_W'(1);
    assign w_last_pkt     = (r_desc.idx == LAST_IDX_V);
    assign w_next_is_last = (w_idx_inc == LAST_IDX_V);

    // One timer serves both the inter-packet gap and the SEND watchdog; the two never overlap.
    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_accept      = 1'b0;
        w_advance     = 1'b0;
        w_set_timeout = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_tmr_dec     = 1'b0;

        if (abort) begin
            w_nxt_state = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame_valid) begin
                        w_accept    = 1'b1;
                        w_nxt_state = START;
                    end
                end
                START: begin
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = WDOG_LOAD_V;
                    w_nxt_state = SEND;
                end
                SEND: begin
                    // A completion landing on the watchdog's final cycle still counts as on time.
                    if (pkt_done) begin
                        if (w_last_pkt) begin
                            w_nxt_state = DONE;
                        end else begin
                            w_advance   = 1'b1;
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = GAP_LOAD_V;
                            w_nxt_state = (IFG_CYCLES > 0) ? GAP : START;
                        end
                    end else if (w_tmr_exp) begin
                        w_set_timeout = 1'b1;
                        w_nxt_state   = IDLE;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                GAP: begin
                    if (w_tmr_exp) begin
                        w_nxt_state = START;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                DONE: begin
                    w_nxt_state = IDLE;
                end
                default: begin
                    w_nxt_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_desc        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_desc.base   <= '0;
                r_desc.idx    <= '0;
                r_desc.len    <= FIRST_LEN_V;
                r_timeout_err <= 1'b0;
            end else if (w_advance) begin
                r_desc.base <= r_desc.base + PKT_STEP_V;
                r_desc.idx  <= w_idx_inc;
                r_desc.len  <= w_next_is_last ? LAST_LEN_V : FULL_LEN_V;
            end
            if (w_set_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign frame_ready   = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign pkt_start     = (r_state == START);
    assign frame_done    = (r_state == DONE);
    assign pkt_base_addr = r_desc.base;
    assign pkt_len       = r_desc.len;
    assign pkt_idx       = r_desc.idx;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Scoreboard bench: stimulus pushes expected pkt_start/frame_done events, monitors pop and compare.
module tb_eth_tx_scheduler;
    import eth_tx_pkg::*;

    localparam int FP   = 10;
    localparam int PP   = 4;
    localparam int IFG  = 3;
    localparam int TO   = 20;
    localparam int FP_B = 8;

    logic clk = 1'b0;
    logic rst_n, frame_valid, abort, pkt_done, frame_valid_b, pkt_done_b;

    logic              frame_ready, pkt_start, busy, frame_done, timeout_err;
    logic [ADDR_W-1:0] pkt_base_addr;
    logic [LEN_W-1:0]  pkt_len;
    logic [IDX_W-1:0]  pkt_idx;

    logic              frame_ready_b, pkt_start_b, busy_b, frame_done_b, timeout_err_b;
    logic [ADDR_W-1:0] pkt_base_addr_b;
    logic [LEN_W-1:0]  pkt_len_b;
    logic [IDX_W-1:0]  pkt_idx_b;

    eth_tx_scheduler #(
        .FRAME_PIXELS (FP), .PKT_PIXELS (PP), .IFG_CYCLES (IFG), .TIMEOUT_CYCLES (TO)
    ) dut_a (
        .clk (clk), .rst_n (rst_n), .frame_valid (frame_valid), .frame_ready (frame_ready),
        .abort (abort), .pkt_done (pkt_done), .pkt_start (pkt_start),
        .pkt_base_addr (pkt_base_addr), .pkt_len (pkt_len), .pkt_idx (pkt_idx),
        .busy (busy), .frame_done (frame_done), .timeout_err (timeout_err)
    );

    eth_tx_scheduler #(
        .FRAME_PIXELS (FP_B), .PKT_PIXELS (PP), .IFG_CYCLES (IFG), .TIMEOUT_CYCLES (TO)
    ) dut_b (
        .clk (clk), .rst_n (rst_n), .frame_valid (frame_valid_b), .frame_ready (frame_ready_b),
        .abort (abort), .pkt_done (pkt_done_b), .pkt_start (pkt_start_b),
        .pkt_base_addr (pkt_base_addr_b), .pkt_len (pkt_len_b), .pkt_idx (pkt_idx_b),
        .busy (busy_b), .frame_done (frame_done_b), .timeout_err (timeout_err_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int cyc;
        int base;
        int len;
        int idx;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic ev_t mk(input bit d, input int c, input int b, input int l, input int i);
        ev_t e;
        e.is_done = d; e.cyc = c; e.base = b; e.len = l; e.idx = i;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t g, input ev_t e);
        bit bad;
        bad = (g.is_done != e.is_done) || (g.cyc != e.cyc);
        if (!e.is_done) bad = bad || (g.base != e.base) || (g.len != e.len) || (g.idx != e.idx);
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got done=%0d cyc=%0d base=%0d len=%0d idx=%0d expected done=%0d cyc=%0d base=%0d len=%0d idx=%0d",
                     nm, g.is_done, g.cyc, g.base, g.len, g.idx, e.is_done, e.cyc, e.base, e.len, e.idx);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    ev_t g_a, e_a, g_b, e_b;

    always @(negedge clk) begin
        if (pkt_start || frame_done) begin
            g_a = mk(!pkt_start, cyc, int'(pkt_base_addr), int'(pkt_len), int'(pkt_idx));
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL ev_a: unexpected event done=%0d at cycle %0d, expected none", g_a.is_done, cyc);
            end else begin
                e_a = q_a.pop_front();
                cmp_ev("ev_a", g_a, e_a);
            end
        end
    end

    always @(negedge clk) begin
        if (pkt_start_b || frame_done_b) begin
            g_b = mk(!pkt_start_b, cyc, int'(pkt_base_addr_b), int'(pkt_len_b), int'(pkt_idx_b));
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL ev_b: unexpected event done=%0d at cycle %0d, expected none", g_b.is_done, cyc);
            end else begin
                e_b = q_b.pop_front();
                cmp_ev("ev_b", g_b, e_b);
            end
        end
    end

    // Full 10-pixel frame on dut_a; spur adds stray pkt_done in START/GAP/DONE and holds frame_valid.
    task automatic run_frame_a(input bit spur);
        int t;
        int eb[3] = '{0, 4, 8};
        int el[3] = '{4, 4, 2};
        frame_valid = 1'b1;
        q_a.push_back(mk(1'b0, cyc + 1, 0, 4, 0));
        tick(1);
        if (!spur) frame_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (spur) begin
                pkt_done = 1'b1; tick(1); pkt_done = 1'b0; tick(4);
            end else begin
                tick(5);
            end
            chk("send_base", pkt_base_addr, eb[p]);
            chk("send_len", pkt_len, el[p]);
            chk("send_idx", pkt_idx, p);
            pkt_done = 1'b1;
            t = cyc;
            if (p < 2) begin
                q_a.push_back(mk(1'b0, t + IFG + 1, eb[p+1], el[p+1], p + 1));
            end else begin
                q_a.push_back(mk(1'b1, t + 1, 0, 0, 0));
                frame_valid = 1'b0;
            end
            tick(1);
            pkt_done = spur;
            if (p < 2) begin
                tick(1); pkt_done = 1'b0; tick(2);
            end else begin
                chk("done_busy", busy, 1);
                chk("done_ready", frame_ready, 0);
                tick(1);
                pkt_done = 1'b0;
                chk("idle_ready", frame_ready, 1);
                chk("idle_busy", busy, 0);
            end
        end
    endtask

    // Frame start plus packet 0 completion; returns at the START cycle of packet 1.
    task automatic start_to_pkt1();
        int t;
        frame_valid = 1'b1;
        q_a.push_back(mk(1'b0, cyc + 1, 0, 4, 0));
        tick(1); frame_valid = 1'b0;
        tick(5); pkt_done = 1'b1; t = cyc;
        q_a.push_back(mk(1'b0, t + IFG + 1, 4, 4, 1));
        tick(1); pkt_done = 1'b0;
        tick(3);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; frame_valid = 1'b0; abort = 1'b0; pkt_done = 1'b0;
        frame_valid_b = 1'b0; pkt_done_b = 1'b0;
        #1;
        chk("rst_ready", frame_ready, 1);
        chk("rst_start", pkt_start, 0);
        chk("rst_fdone", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_base", pkt_base_addr, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_idx", pkt_idx, 0);
        tick(2); rst_n = 1'b1; tick(2);

        // 8-pixel frame: two full packets
        frame_valid_b = 1'b1;
        q_b.push_back(mk(1'b0, cyc + 1, 0, 4, 0));
        tick(1); frame_valid_b = 1'b0;
        for (int p = 0; p < 2; p++) begin
            tick(5); pkt_done_b = 1'b1; t = cyc;
            if (p == 0) q_b.push_back(mk(1'b0, t + IFG + 1, 4, 4, 1));
            else        q_b.push_back(mk(1'b1, t + 1, 0, 0, 0));
            tick(1); pkt_done_b = 1'b0;
            if (p == 0) tick(3);
        end
        tick(3);
        chk("b_ready", frame_ready_b, 1);

        run_frame_a(1'b0);
        run_frame_a(1'b1);
        tick(10);
        chk("spur_no_extra", q_a.size(), 0);
        chk("spur_idle", busy, 0);

        // abort in GAP after packet 0
        frame_valid = 1'b1;
        q_a.push_back(mk(1'b0, cyc + 1, 0, 4, 0));
        tick(1); frame_valid = 1'b0;
        tick(5); pkt_done = 1'b1;
        tick(1); pkt_done = 1'b0; abort = 1'b1;
        chk("abort_gap_busy", busy, 1);
        tick(1); abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ready", frame_ready, 1);
        tick(8);
        chk("abort_no_ev", q_a.size(), 0);
        run_frame_a(1'b0);

        // watchdog on packet 1
        start_to_pkt1();
        tick(TO);
        chk("wd_last_busy", busy, 1);
        chk("wd_last_terr", timeout_err, 0);
        tick(1);
        chk("wd_busy", busy, 0);
        chk("wd_terr", timeout_err, 1);
        chk("wd_ready", frame_ready, 1);
        tick(5);
        chk("wd_sticky", timeout_err, 1);
        chk("wd_no_done", q_a.size(), 0);
        run_frame_a(1'b0);
        chk("wd_cleared", timeout_err, 0);

        // reset in the middle of packet 1 SEND
        start_to_pkt1();
        tick(2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", frame_ready, 1);
        chk("arst_base", pkt_base_addr, 0);
        chk("arst_len", pkt_len, 0);
        chk("arst_idx", pkt_idx, 0);
        chk("arst_start", pkt_start, 0);
        pkt_done = 1'b1;
        tick(3); pkt_done = 1'b0; rst_n = 1'b1;
        tick(10);
        chk("arst_post_busy", busy, 0);

        chk("final_q_a", q_a.size(), 0);
        chk("final_q_b", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
